// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner.
package keypad_pkg;

    localparam int NUM_COLS = 4;
    localparam int COL_W    = 2;
    localparam int ROW_W    = 2;
    localparam int KEY_W    = COL_W + ROW_W;

    // Debounce/hold state of the single tracked key
    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED,
        RELEASE
    } state_t;

    // What one full column sweep saw
    typedef enum logic [1:0] {
        NONE,
        ONE,
        MULTI
    } sweep_t;

endpackage

// File: rtl/keypad_if.sv
// Scanner <-> matrix/consumer signal bundle. The scanner is the master: it
// drives the column select and the key outputs, the matrix drives the rows.
interface keypad_if;
    import keypad_pkg::*;

    logic [COL_W-1:0] col_sel;
    logic [ROW_W-1:0] row_idx;
    logic             row_valid;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_held;

    modport master (
        output col_sel, key_code, key_valid, key_held,
        input  row_idx, row_valid
    );

    modport slave (
        input  col_sel, key_code, key_valid, key_held,
        output row_idx, row_valid
    );

endinterface

// File: rtl/keypad_scan_timebase.sv
// Column dwell divider and column counter. sample is high on the last dwell
// cycle of each column, the cycle on which the synced row is taken.
module scan_timebase
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [COL_W-1:0] col_sel,
    output logic             sample
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    logic [DIV_W-1:0] div;

    assign sample = (div == DIV_W'(SCAN_DIV - 1));

    // Count dwell cycles; advance the column (wrapping 3 -> 0) after the sample
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div     <= '0;
            col_sel <= '0;
        end else if (sample) begin
            div     <= '0;
            col_sel <= col_sel + COL_W'(1);
        end else begin
            div     <= div + DIV_W'(1);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Keypad scanner: synchronizes the row encoder, merges one sample per column
// into a sweep result and debounces presses/releases over whole sweeps.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int CNT_W          = 2
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master bus
);

    logic [COL_W-1:0] col_sel;
    logic             sample;
    logic [ROW_W:0]   sync_p0;
    logic [ROW_W:0]   sync_p1;
    logic [1:0]       hits;
    logic [1:0]       hits_next;
    logic [KEY_W-1:0] hit_code;
    logic [KEY_W-1:0] code_next;
    logic             col_hit;
    logic             eval;
    sweep_t           result;
    state_t           state;
    logic [KEY_W-1:0] cand;
    logic [CNT_W-1:0] cnt;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    scan_timebase #(.SCAN_DIV(SCAN_DIV)) u_timebase (
        .clk     (clk),
        .reset   (reset),
        .col_sel (col_sel),
        .sample  (sample)
    );

    assign bus.col_sel = col_sel;

    // Two-flop synchronizer for the asynchronous {row_valid, row_idx}
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {bus.row_valid, bus.row_idx};
            sync_p1 <= sync_p0;
        end
    end

    // hits saturates at 2: anything beyond one valid column is MULTI
    assign col_hit   = sample && sync_p1[ROW_W];
    assign hits_next = !col_hit ? hits : ((hits == 2'd0) ? 2'd1 : 2'd2);
    assign code_next = (col_hit && hits == 2'd0) ? {col_sel, sync_p1[ROW_W-1:0]}
                                                 : hit_code;
    assign eval      = sample && (col_sel == COL_W'(NUM_COLS - 1));
    assign result    = (hits_next == 2'd0) ? NONE :
                       (hits_next == 2'd1) ? ONE  : MULTI;

    // Sweep accumulators; cleared on the column-3 evaluation cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hits     <= 2'd0;
            hit_code <= '0;
        end else if (eval) begin
            hits     <= 2'd0;
            hit_code <= '0;
        end else if (sample) begin
            hits     <= hits_next;
            hit_code <= code_next;
        end
    end

    // Debounce FSM, stepped once per sweep; outputs registered alongside
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cand          <= '0;
            cnt           <= '0;
            bus.key_code  <= '0;
            bus.key_valid <= 1'b0;
            bus.key_held  <= 1'b0;
        end else begin
            bus.key_valid <= 1'b0;
            if (eval) begin
                case (state)
                    IDLE: begin
                        if (result == ONE) begin
                            cand  <= code_next;
                            cnt   <= CNT_W'(1);
                            state <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (result != ONE) begin
                            state <= IDLE;
                        end else if (code_next != cand) begin
                            cand <= code_next;
                            cnt  <= CNT_W'(1);
                        end else if (cnt >= CNT_LAST) begin
                            state         <= PRESSED;
                            bus.key_code  <= cand;
                            bus.key_valid <= 1'b1;
                            bus.key_held  <= 1'b1;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    PRESSED: begin
                        if (result == NONE) begin
                            cnt   <= CNT_W'(1);
                            state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (result != NONE) begin
                            state <= PRESSED;
                        end else if (cnt >= CNT_LAST) begin
                            state        <= IDLE;
                            bus.key_held <= 1'b0;
                        end else begin
                            cnt <= sat_inc(cnt);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a 4x4 switch matrix model behind the
// column decoder / row encoder. Phases are aligned to sweep boundaries.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] keys;
    logic [3:0]  col_rows;
    int          checks;
    int          errors;
    int          cyc;

    typedef struct {
        logic [15:0] keys;
        int          sweeps;
        int          strobe_sw;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    vec_t vecs[14];

    keypad_if bus ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3), .CNT_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: keys bit index is {col,row}; two rows in one column disable the encoder
    assign col_rows = keys[bus.col_sel*4 +: 4];
    always_comb begin
        bus.row_valid = $onehot(col_rows);
        bus.row_idx   = 2'd0;
        for (int r = 0; r < 4; r++)
            if (col_rows[r]) bus.row_idx = 2'(r);
    end

    function automatic logic [15:0] k(input int col, input int row);
        return 16'(1) << (col * 4 + row);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one key pattern for whole sweeps; count strobes and record where
    task automatic run_phase(input int idx, input vec_t v);
        int nvalid;
        int pos;
        int col_err;
        string tag;
        nvalid  = 0;
        pos     = 0;
        col_err = 0;
        keys    = v.keys;
        for (int i = 1; i <= 16 * v.sweeps; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (int'(bus.col_sel) != (cyc / 4) % 4) col_err++;
            if (bus.key_valid) begin
                nvalid++;
                if (pos == 0) pos = i;
            end
        end
        tag = $sformatf("p%0d", idx);
        chk({tag, "_colseq_errs"}, col_err, 0);
        chk({tag, "_strobes"}, nvalid, (v.strobe_sw != 0) ? 1 : 0);
        chk({tag, "_strobe_cycle"}, pos, v.strobe_sw * 16);
        chk({tag, "_key_code"}, int'(bus.key_code), int'(v.code));
        chk({tag, "_key_held"}, int'(bus.key_held), int'(v.held));
    endtask

    initial begin
        int col_err;
        int busy;
        vec_t v;
        checks = 0;
        errors = 0;
        cyc    = 0;
        keys   = 16'h0;
        reset  = 1'b1;

        //           keys                       sw strobe code     held
        vecs[0]  = '{k(2,1),                     5, 3, 4'b1001, 1'b1}; // press, accept after sweep 3
        vecs[1]  = '{16'h0,                      3, 0, 4'b1001, 1'b0}; // release debounced
        vecs[2]  = '{k(1,0),                     2, 0, 4'b1001, 1'b0}; // bounce: 2 sweeps present
        vecs[3]  = '{16'h0,                      1, 0, 4'b1001, 1'b0}; // gap
        vecs[4]  = '{k(1,0),                     3, 3, 4'b0100, 1'b1}; // 3 fresh sweeps
        vecs[5]  = '{16'h0,                      3, 0, 4'b0100, 1'b0};
        vecs[6]  = '{k(0,0) | k(3,2),            6, 0, 4'b0100, 1'b0}; // multi-key rejected
        vecs[7]  = '{k(2,1),                     3, 3, 4'b1001, 1'b1};
        vecs[8]  = '{16'h0,                      2, 0, 4'b1001, 1'b1}; // short drop
        vecs[9]  = '{k(2,1) | k(0,3),            2, 0, 4'b1001, 1'b1}; // re-press + 2nd key: no strobe
        vecs[10] = '{16'h0,                      3, 0, 4'b1001, 1'b0};
        vecs[11] = '{k(1,3),                     3, 3, 4'b0111, 1'b1};
        vecs[12] = '{16'h0,                      3, 0, 4'b0111, 1'b0};
        vecs[13] = '{k(1,0) | k(1,2),            4, 0, 4'b0111, 1'b0}; // two rows one column

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_col_sel",   int'(bus.col_sel),   0);
        chk("rst_key_valid", int'(bus.key_valid), 0);
        chk("rst_key_held",  int'(bus.key_held),  0);
        chk("rst_key_code",  int'(bus.key_code),  0);
        reset = 1'b0;

        // Idle scan: each column for exactly 4 clk, no outputs
        col_err = 0;
        busy    = 0;
        for (int i = 0; i < 48; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (int'(bus.col_sel) != (cyc / 4) % 4) col_err++;
            if (bus.key_valid || bus.key_held) busy++;
        end
        chk("scan_col_errs", col_err, 0);
        chk("scan_quiet",    busy,    0);

        for (int i = 0; i < 14; i++) run_phase(i, vecs[i]);

        // Reset mid-sweep while debouncing col3,row3
        v = '{k(3,3), 2, 0, 4'b0111, 1'b0};
        run_phase(14, v);
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("pre_rst_col_sel", int'(bus.col_sel), 2);
        reset = 1'b1;
        #1;
        chk("mid_rst_col_sel",   int'(bus.col_sel),   0);
        chk("mid_rst_key_code",  int'(bus.key_code),  0);
        chk("mid_rst_key_valid", int'(bus.key_valid), 0);
        chk("mid_rst_key_held",  int'(bus.key_held),  0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        v = '{k(3,3), 2, 0, 4'b0000, 1'b0};
        run_phase(15, v);
        v = '{k(3,3), 1, 1, 4'b1111, 1'b1};
        run_phase(16, v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
